// File: rtl/scalar_writeback_stage.sv
// scalar_writeback_stage: 2-entry skid buffer that retires ALU results in order to the
// register file and resolves branches/JAL into a registered PC redirect plus flush pulse.
module scalar_writeback_stage #(
  parameter int DATA_LEN       = 32,
  parameter int SCALAR_REG_LEN = 64,
  parameter int REG_INDEX_SIZE = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SCALAR_REG_LEN-1:0] in_result,
  input  logic [1:0]                in_sign_bits,
  input  logic [1:0]                in_kind,
  input  logic [2:0]                in_branch_func,
  input  logic [REG_INDEX_SIZE-1:0] in_rd,
  input  logic [DATA_LEN-1:0]       in_pc,
  input  logic [DATA_LEN-1:0]       in_target,
  input  logic                      rf_ready,
  output logic                      rf_we,
  output logic [REG_INDEX_SIZE-1:0] rf_waddr,
  output logic [SCALAR_REG_LEN-1:0] rf_wdata,
  output logic                      redirect_valid,
  output logic [DATA_LEN-1:0]       redirect_pc,
  output logic                      flush,
  output logic                      err,
  output logic [31:0]               retire_cnt
);
  // ALU sign codes: POS=0, ZERO=1, NEG=2
  localparam logic [1:0] ZERO = 2'd1, NEG = 2'd2;
  localparam logic [1:0] K_WB = 2'd1, K_BR = 2'd2, K_JAL = 2'd3;
  typedef struct packed {
    logic [SCALAR_REG_LEN-1:0] result;
    logic [1:0]                sign;
    logic [1:0]                kind;
    logic [2:0]                func;
    logic [REG_INDEX_SIZE-1:0] rd;
    logic [DATA_LEN-1:0]       pc;
    logic [DATA_LEN-1:0]       target;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q, state_d;
  entry_t e0_q, e1_q, e0_d, e1_d, new_e;
  logic acc, ret, wr, need_rf, taken, bad, redir, slot0;
  assign in_ready = !rst && state_q != TWO;
  assign acc = in_valid && in_ready;
  assign new_e = {in_result, in_sign_bits, in_kind, in_branch_func, in_rd, in_pc, in_target};
  assign wr = e0_q.kind == K_WB || e0_q.kind == K_JAL;
  assign need_rf = wr && e0_q.rd != '0;
  assign ret = state_q != EMPTY && (!need_rf || rf_ready);
  assign bad = e0_q.kind == K_BR && e0_q.func[1];
  assign redir = ret && (e0_q.kind == K_JAL || (e0_q.kind == K_BR && taken));
  always_comb begin
    taken = e0_q.func == 3'b000 ? e0_q.sign == ZERO :
            e0_q.func == 3'b001 ? e0_q.sign != ZERO :
            e0_q.func == 3'b100 ? e0_q.sign == NEG  :
            e0_q.func == 3'b101 ? e0_q.sign != NEG  : 1'b0;
    slot0 = state_q == EMPTY || (state_q == ONE && ret);
    e0_d = ret ? e1_q : e0_q;
    e1_d = e1_q;
    if (acc && slot0) e0_d = new_e;
    if (acc && !slot0) e1_d = new_e;
    // a redirecting retire discards the younger entry and any same-edge accept
    state_d = redir ? EMPTY :
              state_q == EMPTY ? (acc ? ONE : EMPTY) :
              state_q == ONE ? (acc && !ret ? TWO : (!acc && ret ? EMPTY : ONE)) :
              (ret ? ONE : TWO);
  end
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
    if (rst) begin
      state_q        <= EMPTY;
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      err            <= 1'b0;
      retire_cnt     <= '0;
    end else begin
      state_q        <= state_d;
      rf_we          <= ret && need_rf;
      redirect_valid <= redir;
      flush          <= redir;
      if (ret && wr) begin
        rf_waddr <= e0_q.rd;
        rf_wdata <= e0_q.kind == K_JAL ? {{(SCALAR_REG_LEN-DATA_LEN){1'b0}}, e0_q.pc + DATA_LEN'(4)} : e0_q.result;
      end
      if (redir) redirect_pc <= e0_q.kind == K_JAL ? e0_q.result[DATA_LEN-1:0] : e0_q.target;
      if (ret && bad) err <= 1'b1;
      if (ret) retire_cnt <= retire_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_scalar_writeback_stage.sv
// tb_scalar_writeback_stage: directed and random stimulus checked against a queue-based reference model.
module tb_scalar_writeback_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, in_valid = 1'b0, in_ready, rf_ready = 1'b0;
  logic [63:0] in_result = '0;
  logic [1:0] in_sign_bits = '0, in_kind = '0;
  logic [2:0] in_branch_func = '0;
  logic [4:0] in_rd = '0;
  logic [31:0] in_pc = '0, in_target = '0;
  logic rf_we, redirect_valid, flush, err;
  logic [4:0] rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] redirect_pc, retire_cnt;
  scalar_writeback_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_sign_bits(in_sign_bits), .in_kind(in_kind), .in_branch_func(in_branch_func), .in_rd(in_rd),
    .in_pc(in_pc), .in_target(in_target), .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .err(err), .retire_cnt(retire_cnt)
  );
  localparam logic [1:0] POS = 2'd0, ZERO = 2'd1, NEG = 2'd2;
  typedef struct {
    logic [63:0] res;
    logic [1:0]  sg;
    logic [1:0]  kd;
    logic [2:0]  fn;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] tg;
  } ent_t;
  ent_t q[$];
  int n_chk = 0, n_fail = 0;
  logic x_we = 0, x_rv = 0, x_fl = 0, x_err = 0;
  logic [4:0] x_waddr = 0;
  logic [63:0] x_wdata = 0;
  logic [31:0] x_rpc = 0, x_cnt = 0;
  task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic ent_t mk(input logic [1:0] kd, input logic [4:0] rd, input logic [63:0] res,
                              input logic [1:0] sg, input logic [2:0] fn, input logic [31:0] pc,
                              input logic [31:0] tg);
    ent_t e;
    e.kd = kd; e.rd = rd; e.res = res; e.sg = sg; e.fn = fn; e.pc = pc; e.tg = tg;
    return e;
  endfunction
  function automatic logic br_taken(input ent_t e, output logic known);
    known = 1'b1;
    case (e.fn)
      3'b000:  return e.sg == ZERO;
      3'b001:  return e.sg != ZERO;
      3'b100:  return e.sg == NEG;
      3'b101:  return e.sg != NEG;
      default: begin known = 1'b0; return 1'b0; end
    endcase
  endfunction
  task step(input logic r, input logic v, input ent_t e, input logic rdy);
    logic acc, known, tk;
    ent_t h;
    @(negedge clk);
    rst = r; in_valid = v; rf_ready = rdy;
    in_result = e.res; in_sign_bits = e.sg; in_kind = e.kd; in_branch_func = e.fn;
    in_rd = e.rd; in_pc = e.pc; in_target = e.tg;
    #1 chk("in_ready", in_ready, !r && q.size() < 2);
    @(posedge clk);
    if (r) begin
      q.delete();
      {x_we, x_rv, x_fl, x_err, x_waddr, x_wdata, x_rpc, x_cnt} = '0;
    end else begin
      acc = v && q.size() < 2;
      x_we = 0; x_rv = 0; x_fl = 0;
      if (q.size() > 0) begin
        h = q[0];
        if (!((h.kd == 1 || h.kd == 3) && h.rd != 0) || rdy) begin
          void'(q.pop_front());
          x_cnt++;
          if (h.kd == 1 || h.kd == 3) begin
            x_we = h.rd != 0;
            x_waddr = h.rd;
            x_wdata = h.kd == 3 ? 64'(h.pc + 32'd4) : h.res;
          end
          if (h.kd == 3) begin x_rv = 1; x_rpc = h.res[31:0]; end
          if (h.kd == 2) begin
            tk = br_taken(h, known);
            if (!known) x_err = 1;
            if (tk) begin x_rv = 1; x_rpc = h.tg; end
          end
          if (x_rv) begin x_fl = 1; q.delete(); acc = 0; end
        end
      end
      if (acc) q.push_back(e);
    end
    #1;
    chk("rf_we", rf_we, x_we);
    chk("rf_waddr", rf_waddr, x_waddr);
    chk("rf_wdata", rf_wdata, x_wdata);
    chk("redirect_valid", redirect_valid, x_rv);
    chk("redirect_pc", redirect_pc, x_rpc);
    chk("flush", flush, x_fl);
    chk("err", err, x_err);
    chk("retire_cnt", retire_cnt, x_cnt);
  endtask
  ent_t nop, e;
  initial begin
    nop = mk(0, 0, 0, POS, 0, 0, 0);
    step(1, 0, nop, 0);
    step(1, 0, nop, 0);
    step(0, 1, mk(1, 5, 64'h1234, POS, 0, 32'h10, 0), 1);
    step(0, 0, nop, 1);
    step(0, 0, nop, 1);
    chk("first_write_cnt", retire_cnt, 32'd1);
    step(0, 1, mk(1, 1, 64'h11, POS, 0, 0, 0), 0);
    step(0, 1, mk(1, 2, 64'h22, POS, 0, 0, 0), 0);
    step(0, 1, mk(1, 3, 64'h33, POS, 0, 0, 0), 0);
    step(0, 1, mk(1, 3, 64'h33, POS, 0, 0, 0), 0);
    step(0, 1, mk(1, 3, 64'h33, POS, 0, 0, 0), 1);
    step(0, 1, mk(1, 3, 64'h33, POS, 0, 0, 0), 1);
    repeat (3) step(0, 0, nop, 1);
    step(0, 1, mk(2, 0, 0, ZERO, 3'b000, 32'h80, 32'h100), 1);
    step(0, 1, mk(1, 7, 64'h77, POS, 0, 0, 0), 1);
    repeat (2) step(0, 0, nop, 1);
    step(0, 1, mk(2, 0, 0, POS, 3'b100, 32'h84, 32'h300), 1);
    step(0, 1, mk(2, 0, 0, POS, 3'b101, 32'h88, 32'h400), 1);
    repeat (2) step(0, 0, nop, 1);
    step(0, 1, mk(3, 1, 64'h200, POS, 0, 32'h40, 0), 1);
    repeat (2) step(0, 0, nop, 1);
    step(0, 1, mk(3, 0, 64'h500, POS, 0, 32'h60, 0), 1);
    repeat (2) step(0, 0, nop, 1);
    step(0, 1, mk(2, 0, 0, ZERO, 3'b010, 32'h90, 32'h600), 1);
    repeat (2) step(0, 0, nop, 1);
    step(0, 1, mk(1, 4, 64'h44, POS, 0, 0, 0), 0);
    step(0, 1, mk(1, 6, 64'h66, POS, 0, 0, 0), 0);
    step(1, 0, nop, 1);
    repeat (3) step(0, 0, nop, 1);
    for (int i = 0; i < 2000; i++) begin
      e = mk(2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), {$urandom, $urandom},
             2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, e, $urandom_range(0, 2) != 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
